// File: rtl/sync_ptr_mc_pkg.sv
// Shared helpers for the asynchronous FIFO pointer logic: Gray-to-binary
// conversion and a "more than one bit set" test. Operands are carried at a
// fixed width FW; callers zero-extend narrower pointers, which leaves both
// results unchanged for the low bits.
package sync_pkg;

    localparam int DEF_ASIZE = 4;
    localparam int DEF_PW    = DEF_ASIZE + 1;   // pointer width: address bits plus wrap bit
    localparam int FW        = 32;              // operand width of the helper functions

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [FW-1:0] gray2bin(input logic [FW-1:0] g);
        logic [FW-1:0] b;
        b        = '0;
        b[FW-1]  = g[FW-1];
        for (int i = FW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit of x is set (clearing the lowest set bit leaves something).
    function automatic logic popcount_gt1(input logic [FW-1:0] x);
        return ((x & (x - FW'(1'b1))) != '0);
    endfunction

endpackage

// File: rtl/sync_ptr_ch.sv
// One pointer channel: plain flop chain into the local clock domain, then a
// registered output stage producing the Gray/binary pointer, an update pulse,
// the binary advance and a sticky multi-bit-hop error.
module sync_ptr_ch
    import sync_pkg::*;
#(
    parameter int ASIZE  = DEF_ASIZE,
    parameter int STAGES = 2
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [ASIZE:0]   gptr_in,
    input  logic             err_clr,
    output logic [ASIZE:0]   gptr_sync,
    output logic [ASIZE:0]   bptr_sync,
    output logic             ptr_upd,
    output logic [ASIZE:0]   ptr_delta,
    output logic             hop_err
);

    localparam int PW = ASIZE + 1;

    logic [PW-1:0] chain_q [STAGES];
    logic [PW-1:0] gptr_q, bptr_q, delta_q;
    logic          upd_q, hop_q;

    logic [PW-1:0] s_last;
    logic [PW-1:0] diff;
    logic [PW-1:0] gptr_d, bin_d, delta_d;
    logic          upd_d, hop_d;

    // Synchroniser chain: no logic between flops so each stage can resolve.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q[0] <= gptr_in;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    // Output-stage next state: compare the settled sample with the last one seen.
    always_comb begin
        s_last  = chain_q[STAGES-1];
        diff    = s_last ^ gptr_q;
        gptr_d  = s_last;
        bin_d   = PW'(gray2bin(FW'(s_last)));
        upd_d   = (diff != '0);
        delta_d = bin_d - bptr_q;          // modular advance; zero when unchanged
        // A new hop takes priority over a clear on the same edge.
        if (popcount_gt1(FW'(diff))) begin
            hop_d = 1'b1;
        end else if (err_clr) begin
            hop_d = 1'b0;
        end else begin
            hop_d = hop_q;
        end
    end

    // Output registers; illegal samples are passed through unfiltered.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            gptr_q  <= '0;
            bptr_q  <= '0;
            upd_q   <= 1'b0;
            delta_q <= '0;
            hop_q   <= 1'b0;
        end else begin
            gptr_q  <= gptr_d;
            bptr_q  <= bin_d;
            upd_q   <= upd_d;
            delta_q <= delta_d;
            hop_q   <= hop_d;
        end
    end

    assign gptr_sync = gptr_q;
    assign bptr_sync = bptr_q;
    assign ptr_upd   = upd_q;
    assign ptr_delta = delta_q;
    assign hop_err   = hop_q;

endmodule

// File: rtl/sync_ptr_mc.sv
// Multi-channel Gray-pointer synchroniser: NCH independent sync_ptr_ch
// instances, each owning one ASIZE+1-bit slice of the pointer buses.
module sync_ptr_mc
    import sync_pkg::*;
#(
    parameter int ASIZE  = DEF_ASIZE,
    parameter int NCH    = 1,
    parameter int STAGES = 2
) (
    input  logic                     rclk,
    input  logic                     rrst,
    input  logic [NCH*(ASIZE+1)-1:0] gptr_in,
    input  logic [NCH-1:0]           err_clr,
    output logic [NCH*(ASIZE+1)-1:0] gptr_sync,
    output logic [NCH*(ASIZE+1)-1:0] bptr_sync,
    output logic [NCH-1:0]           ptr_upd,
    output logic [NCH*(ASIZE+1)-1:0] ptr_delta,
    output logic [NCH-1:0]           hop_err
);

    localparam int PW = ASIZE + 1;

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ptr_mc: STAGES must be at least 2");
    end
    if (NCH < 1) begin : g_bad_nch
        $error("sync_ptr_mc: NCH must be at least 1");
    end
    if (PW > FW) begin : g_bad_asize
        $error("sync_ptr_mc: pointer wider than helper operand width");
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        sync_ptr_ch #(
            .ASIZE  (ASIZE),
            .STAGES (STAGES)
        ) u_ch (
            .rclk      (rclk),
            .rrst      (rrst),
            .gptr_in   (gptr_in[c*PW +: PW]),
            .err_clr   (err_clr[c]),
            .gptr_sync (gptr_sync[c*PW +: PW]),
            .bptr_sync (bptr_sync[c*PW +: PW]),
            .ptr_upd   (ptr_upd[c]),
            .ptr_delta (ptr_delta[c*PW +: PW]),
            .hop_err   (hop_err[c])
        );
    end

endmodule

// File: tb/tb_sync_ptr_mc.sv
// Scoreboard bench for sync_ptr_mc: stimulus pushes the hand-computed
// expected update per channel; a negedge monitor pops and compares whenever
// a channel pulses ptr_upd. A second single-channel instance with STAGES=3
// covers the deeper-chain latency.
module tb_sync_ptr_mc;

    localparam int ASIZE = 4;
    localparam int PW    = ASIZE + 1;
    localparam int NCH   = 4;

    typedef struct packed {
        logic [PW-1:0] bptr;
        logic [PW-1:0] delta;
        logic          hop;
    } ev_t;

    logic                rclk = 1'b0;
    logic                rrst;
    logic [NCH*PW-1:0]   gptr_in;
    logic [NCH-1:0]      err_clr;
    logic [NCH*PW-1:0]   gptr_sync, bptr_sync, ptr_delta;
    logic [NCH-1:0]      ptr_upd, hop_err;

    logic [PW-1:0]       g3_in, g3_sync, b3_sync, d3;
    logic                clr3, u3, h3;

    int   errors = 0;
    int   checks = 0;
    ev_t  exp_q [NCH][$];
    int   pulse_cnt [NCH] = '{0, 0, 0, 0};

    // Multi-channel table: binary value per slot, hand-computed delta (0 = no change), hop flag.
    int tab  [NCH][4] = '{'{1, 2, 3, 4}, '{31, 30, 29, 28}, '{0, 0, 1, 1}, '{3, 3, 6, 6}};
    int dtab [NCH][4] = '{'{1, 1, 1, 1}, '{31, 31, 31, 31}, '{0, 0, 1, 0}, '{3, 0, 3, 0}};
    bit htab [NCH][4] = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 1, 0}};

    always #5 rclk = ~rclk;

    sync_ptr_mc #(.ASIZE(ASIZE), .NCH(NCH), .STAGES(2)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .gptr_in   (gptr_in),
        .err_clr   (err_clr),
        .gptr_sync (gptr_sync),
        .bptr_sync (bptr_sync),
        .ptr_upd   (ptr_upd),
        .ptr_delta (ptr_delta),
        .hop_err   (hop_err)
    );

    sync_ptr_mc #(.ASIZE(ASIZE), .NCH(1), .STAGES(3)) dut3 (
        .rclk      (rclk),
        .rrst      (rrst),
        .gptr_in   (g3_in),
        .err_clr   (clr3),
        .gptr_sync (g3_sync),
        .bptr_sync (b3_sync),
        .ptr_upd   (u3),
        .ptr_delta (d3),
        .hop_err   (h3)
    );

    function automatic logic [PW-1:0] bin2gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ch(input int c, input int b, input int ed, input bit eh);
        ev_t e;
        gptr_in[c*PW +: PW] = bin2gray(b);
        e.bptr  = PW'(b);
        e.delta = PW'(ed);
        e.hop   = eh;
        exp_q[c].push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge rclk);
    endtask

    task automatic chk_drained(input string tag);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s_missing_upd_ch%0d", tag, c), exp_q[c].size(), 0);
        end
    endtask

    // Monitor: every pulse must match the oldest expected update; idle cycles carry zero delta.
    always @(negedge rclk) begin
        ev_t e;
        if (!rrst) begin
            for (int c = 0; c < NCH; c++) begin
                if (ptr_upd[c]) begin
                    pulse_cnt[c]++;
                    if (exp_q[c].size() == 0) begin
                        chk($sformatf("unexpected_upd_ch%0d", c), 1, 0);
                    end else begin
                        e = exp_q[c].pop_front();
                        chk($sformatf("bptr_ch%0d", c), int'(bptr_sync[c*PW +: PW]), int'(e.bptr));
                        chk($sformatf("gptr_ch%0d", c), int'(gptr_sync[c*PW +: PW]), int'(bin2gray(int'(e.bptr))));
                        chk($sformatf("delta_ch%0d", c), int'(ptr_delta[c*PW +: PW]), int'(e.delta));
                        chk($sformatf("hop_ch%0d", c), int'(hop_err[c]), int'(e.hop));
                    end
                end else begin
                    chk($sformatf("idle_delta_ch%0d", c), int'(ptr_delta[c*PW +: PW]), 0);
                end
            end
        end
    end

    initial begin
        int first2, first3, w2, w3, base;

        // Reset with toggling inputs: everything stays zero.
        rrst = 1'b1; gptr_in = '0; err_clr = '0; g3_in = '0; clr3 = 1'b0;
        repeat (4) begin
            @(negedge rclk);
            gptr_in = (NCH*PW)'($urandom);
            g3_in   = PW'($urandom);
        end
        @(negedge rclk);
        chk("rst_zero", int'(gptr_sync == '0 && bptr_sync == '0 && ptr_delta == '0 &&
                             ptr_upd == '0 && hop_err == '0), 1);
        chk("rst_zero_s3", int'(g3_sync == '0 && b3_sync == '0 && d3 == '0 && !u3 && !h3), 1);
        gptr_in = '0; g3_in = '0;
        @(negedge rclk);
        rrst = 1'b0;
        cycles(6);
        chk("rst_release_hop", int'(hop_err), 0);
        chk("rst_release_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);

        // Latency: 0 -> 1 on both depths.
        set_ch(0, 1, 1, 1'b0);
        g3_in = bin2gray(1);
        first2 = 0; first3 = 0; w2 = 0; w3 = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge rclk);
            #1;
            if (ptr_upd[0]) begin
                w2++;
                if (first2 == 0) first2 = n;
            end
            if (u3) begin
                w3++;
                if (first3 == 0) first3 = n;
                chk("s3_bptr", int'(b3_sync), 1);
                chk("s3_delta", int'(d3), 1);
            end
        end
        chk("latency_s2", first2, 3);
        chk("latency_s3", first3, 4);
        chk("pulse_width_s2", w2, 1);
        chk("pulse_width_s3", w3, 1);
        @(negedge rclk);

        // Counting sequence 2..34 on channel 0, crossing the 31 -> 0 wrap.
        base = pulse_cnt[0];
        for (int i = 2; i <= 34; i++) begin
            set_ch(0, i, 1, 1'b0);
            cycles(3);
        end
        cycles(4);
        chk("wrap_pulses", pulse_cnt[0] - base, 33);
        chk("wrap_hop", int'(hop_err[0]), 0);
        chk_drained("wrap");

        // Hops from binary 2: 5 and 10 are single-bit Gray steps, 10 -> 0 is not.
        set_ch(0, 5, 3, 1'b0);   cycles(3);
        set_ch(0, 10, 5, 1'b0);  cycles(3);
        set_ch(0, 0, 22, 1'b1);  cycles(4);
        chk("hop_set", int'(hop_err[0]), 1);
        chk("hop_other_ch", int'(hop_err[3:1]), 0);
        err_clr[0] = 1'b1;
        @(negedge rclk);
        err_clr[0] = 1'b0;
        chk("hop_clear", int'(hop_err[0]), 0);

        // Clear coinciding with a new 3-bit hop (0 -> Gray(5)): set wins.
        cycles(1);
        set_ch(0, 5, 5, 1'b1);
        @(posedge rclk);
        @(posedge rclk);
        @(negedge rclk);
        err_clr[0] = 1'b1;
        @(negedge rclk);
        err_clr[0] = 1'b0;
        chk("collision_hop", int'(hop_err[0]), 1);
        err_clr[0] = 1'b1;
        @(negedge rclk);
        err_clr[0] = 1'b0;
        chk("collision_clear", int'(hop_err[0]), 0);
        chk_drained("hop");

        // Return all channels to zero before the multi-channel table.
        rrst = 1'b1; gptr_in = '0;
        @(negedge rclk);
        rrst = 1'b0;
        cycles(4);

        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < NCH; c++) begin
                if (dtab[c][s] != 0) set_ch(c, tab[c][s], dtab[c][s], htab[c][s]);
            end
            cycles(3);
        end
        cycles(4);
        chk("multi_hop", int'(hop_err), 8);
        chk_drained("multi");

        // Reset while new values are inside the chain, then restart from zero.
        gptr_in = {NCH{bin2gray(9)}};
        @(posedge rclk);
        #2 rrst = 1'b1;
        @(negedge rclk);
        chk("mid_rst_zero", int'(gptr_sync == '0 && bptr_sync == '0 && ptr_delta == '0 &&
                                 ptr_upd == '0 && hop_err == '0), 1);
        repeat (3) begin
            @(negedge rclk);
            gptr_in = (NCH*PW)'($urandom);
        end
        @(negedge rclk);
        gptr_in = '0;
        set_ch(0, 1, 1, 1'b0);
        set_ch(1, 31, 31, 1'b0);
        set_ch(2, 1, 1, 1'b0);
        set_ch(3, 3, 3, 1'b0);
        rrst = 1'b0;
        cycles(6);
        chk("restart_hop", int'(hop_err), 0);
        chk_drained("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
